// File: rtl/mem_wb_connection_test_pkg.sv
// Shared widths and the MEM/WB pipeline register layout.
package mem_wb_connection_test_pkg;

  localparam int DEF_DATA_W     = 24;
  localparam int DEF_DEST_W     = 4;
  localparam int DEF_MEM_ADDR_W = 8;

  typedef struct packed {
    logic                  wb_en;
    logic [DEF_DEST_W-1:0] dest;
    logic [DEF_DATA_W-1:0] data;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_connection_test_data_memory.sv
// Word-addressed data memory: synchronous write, combinational read, zero at power-up.
// Read returns pre-write contents during a same-cycle write to the same word.
module data_memory #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_connection_test.sv
// MEM stage: data memory access, writeback select and MEM/WB register.
// One-cycle latency to the outputs; no stall or flush, a new value is captured every edge.
module mem_wb_connection_test
  import mem_wb_connection_test_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEST_W     = DEF_DEST_W,
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W
) (
  input  logic              clk_a,
  input  logic              rst,
  input  logic              writeback_enable,
  input  logic              read_enable,
  input  logic              write_enable,
  input  logic [DEST_W-1:0] instruction_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data_a,
  output logic              writeback_enable_out,
  output logic [DEST_W-1:0] instruction_dest_out,
  output logic [DATA_W-1:0] writeback_data_out
);

  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] wb_data;
  logic              mem_we;
  mem_wb_t           stage;

  // Stores arriving while reset is held must not reach the memory.
  assign mem_we = write_enable & ~rst;

  data_memory #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_data_memory (
    .clk   (clk_a),
    .we    (mem_we),
    .addr  (alu_result[MEM_ADDR_W-1:0]),
    .wdata (write_data_a),
    .rdata (mem_rdata)
  );

  assign wb_data = read_enable ? mem_rdata : alu_result;

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage.wb_en <= writeback_enable;
      stage.dest  <= instruction_dest;
      stage.data  <= wb_data;
    end
  end

  assign writeback_enable_out = stage.wb_en;
  assign instruction_dest_out = stage.dest;
  assign writeback_data_out   = stage.data;

endmodule

// File: tb/tb_mem_wb_connection_test.sv
// Scoreboard bench: the driver queues expected WB outputs, a monitor compares after each edge.
module tb_mem_wb_connection_test;

  logic        clk_a = 1'b0;
  logic        rst   = 1'b1;
  logic        writeback_enable = 1'b0;
  logic        read_enable      = 1'b0;
  logic        write_enable     = 1'b0;
  logic [3:0]  instruction_dest = '0;
  logic [23:0] alu_result       = '0;
  logic [23:0] write_data_a     = '0;
  logic        writeback_enable_out;
  logic [3:0]  instruction_dest_out;
  logic [23:0] writeback_data_out;

  mem_wb_connection_test dut (
    .clk_a                (clk_a),
    .rst                  (rst),
    .writeback_enable     (writeback_enable),
    .read_enable          (read_enable),
    .write_enable         (write_enable),
    .instruction_dest     (instruction_dest),
    .alu_result           (alu_result),
    .write_data_a         (write_data_a),
    .writeback_enable_out (writeback_enable_out),
    .instruction_dest_out (instruction_dest_out),
    .writeback_data_out   (writeback_data_out)
  );

  always #5 clk_a = ~clk_a;

  typedef struct {
    logic        wb;
    logic [3:0]  dest;
    logic [23:0] data;
  } exp_t;

  exp_t        sbq[$];
  logic [23:0] model[int];   // sparse memory model, absent words read as zero
  int          checks = 0;
  int          errors = 0;

  function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [23:0] model_read(logic [23:0] alu);
    int a = int'(alu % 256);
    return model.exists(a) ? model[a] : 24'h0;
  endfunction

  // Drive one instruction at the current (negedge) time and queue its expected result.
  task automatic drive(input logic wb, input logic rd, input logic we,
                       input logic [3:0] dest, input logic [23:0] alu, input logic [23:0] wd);
    exp_t e;
    writeback_enable = wb;
    read_enable      = rd;
    write_enable     = we;
    instruction_dest = dest;
    alu_result       = alu;
    write_data_a     = wd;
    e.wb   = wb;
    e.dest = dest;
    e.data = rd ? model_read(alu) : alu;
    sbq.push_back(e);
    if (we) model[int'(alu % 256)] = wd;
    @(posedge clk_a);
  endtask

  task automatic step(input logic wb, input logic rd, input logic we,
                      input logic [3:0] dest, input logic [23:0] alu, input logic [23:0] wd);
    @(negedge clk_a);
    drive(wb, rd, we, dest, alu, wd);
  endtask

  task automatic check_cleared(string tag);
    cmp({tag, "_wb"},   {31'h0, writeback_enable_out}, 32'h0);
    cmp({tag, "_dest"}, {28'h0, instruction_dest_out}, 32'h0);
    cmp({tag, "_data"}, {8'h0, writeback_data_out},    32'h0);
  endtask

  always @(posedge clk_a) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: output cycle with no queued expectation");
      end else begin
        e = sbq.pop_front();
        cmp("wb_out",   {31'h0, writeback_enable_out}, {31'h0, e.wb});
        cmp("dest_out", {28'h0, instruction_dest_out}, {28'h0, e.dest});
        cmp("data_out", {8'h0, writeback_data_out},    {8'h0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with nonzero inputs, including a store that must be ignored.
    writeback_enable = 1'b1;
    instruction_dest = 4'hF;
    alu_result       = 24'h000005;
    write_data_a     = 24'h999999;
    write_enable     = 1'b1;
    #2;
    check_cleared("reset_init");
    repeat (2) @(posedge clk_a);
    #2;
    check_cleared("reset_edge");

    // Release and run ALU pass-through.
    @(negedge clk_a);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd1, 24'h000001, 24'h0);
    step (1'b1, 1'b0, 1'b0, 4'd1, 24'h000002, 24'h0);
    // Load from memory that has only seen an ignored store.
    step (1'b0, 1'b1, 1'b0, 4'd2, 24'h000001, 24'h0);
    step (1'b1, 1'b1, 1'b0, 4'd3, 24'h000005, 24'h0);
    // Store then load, including an aliased address.
    step (1'b0, 1'b0, 1'b1, 4'd0, 24'h000005, 24'hABCDEF);
    step (1'b1, 1'b1, 1'b0, 4'd4, 24'h000005, 24'h0);
    step (1'b1, 1'b1, 1'b0, 4'd5, 24'h000105, 24'h0);
    // Same-cycle read and write of one word.
    step (1'b0, 1'b0, 1'b1, 4'd0, 24'h000007, 24'h000011);
    step (1'b1, 1'b1, 1'b1, 4'd6, 24'h000007, 24'h000022);
    step (1'b1, 1'b1, 1'b0, 4'd6, 24'h000007, 24'h0);

    // Randomized mix over a small set of words with random upper address bits.
    for (int i = 0; i < 300; i++) begin
      logic [23:0] alu;
      alu[7:0]  = 8'($urandom_range(0, 15));
      alu[23:8] = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           4'($urandom), alu, 24'($urandom));
    end

    // Reset in the middle of a load; a store to word 5 during reset is dropped.
    step(1'b0, 1'b0, 1'b1, 4'd0, 24'h000005, 24'hABCDEF);
    step(1'b1, 1'b1, 1'b0, 4'd9, 24'h000005, 24'h0);
    #2;
    write_enable = 1'b1;
    write_data_a = 24'h123456;
    rst = 1'b1;
    #1;
    check_cleared("reset_mid");
    @(posedge clk_a);
    #2;
    check_cleared("reset_mid_edge");
    @(negedge clk_a);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd10, 24'h000005, 24'h0);
    step (1'b1, 1'b1, 1'b0, 4'd11, 24'h000205, 24'h0);

    @(negedge clk_a);
    rst = 1'b1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_connection_test.md
MEM_WB_CONNECTION_TEST -- requirements
Module: mem_wb_connection_test

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the width of the data path, ALU result and memory word.
REQ-002 SHALL have parameter DEST_W, default 4, meaning the width of the destination register index.
REQ-003 SHALL have parameter MEM_ADDR_W, default 8, meaning the data memory address width (256 words).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk_a, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, width 1: asynchronous active-high reset.
REQ-007 SHALL have port writeback_enable, input, width 1: MEM-stage register-write flag.
REQ-008 SHALL have port read_enable, input, width 1: load instruction; selects memory data for writeback.
REQ-009 SHALL have port write_enable, input, width 1: store instruction; writes data memory.
REQ-010 SHALL have port instruction_dest, input, DEST_W: destination register index.
REQ-011 SHALL have port alu_result, input, DATA_W: ALU result, which is also the memory byte-free word address.
REQ-012 SHALL have port write_data_a, input, DATA_W: store data.
REQ-013 SHALL have port writeback_enable_out, output, width 1: registered WB-stage write flag.
REQ-014 SHALL have port instruction_dest_out, output, DEST_W: registered destination index.
REQ-015 SHALL have port writeback_data_out, output, DATA_W: registered writeback value.

Function
REQ-016 Data memory SHALL be 2**MEM_ADDR_W words of DATA_W bits, addressed by alu_result[MEM_ADDR_W-1:0]; upper address bits are ignored (wrap-around).
REQ-017 Memory write SHALL be synchronous: when write_enable=1 at a rising clk_a edge, mem[addr] <= write_data_a.
REQ-018 Memory read SHALL be combinational (asynchronous) from the current address.
REQ-019 Writeback mux: when read_enable=1, the selected data is mem[addr]; otherwise it is alu_result.
REQ-020 The MEM/WB register SHALL capture writeback_enable, instruction_dest and the mux output on every rising clk_a edge, giving 1-cycle latency to the outputs; there is no stall or flush input.
REQ-021 Simultaneous read_enable=1 and write_enable=1 to the same address SHALL register the old memory contents; the new data is visible from the next cycle.
REQ-022 writeback_enable does not gate memory access; read_enable and write_enable act independently of it.
REQ-023 Memory contents SHALL initialise to zero at power-up/simulation start.

Reset
REQ-024 While rst=1, writeback_enable_out SHALL be 0, instruction_dest_out 0 and writeback_data_out 0, immediately and independent of clk_a.
REQ-025 Reset SHALL NOT alter memory contents; a store presented during reset is ignored.
REQ-026 After rst deasserts, the first rising edge captures the inputs normally.

Structure
REQ-027 A shared package SHALL hold DATA_W, DEST_W and MEM_ADDR_W defaults and a struct type for the MEM/WB register fields (wb_en, dest, data).
REQ-028 The data memory SHALL be a separate sub-module named data_memory (clk, we, addr, wdata, rdata); the mux and pipeline register live in the top module.

Verification
REQ-029 Reset: assert rst with nonzero inputs -> all outputs 0 immediately; deassert -> values follow after the next edge.
REQ-030 ALU pass-through: wb=1, rd=0, dest=1, alu=1 -> after one edge, outputs wb=1, dest=1, data=0x000001; then wb=1, dest=1, alu=2 -> data=0x000002.
REQ-031 Load from zeroed memory: wb=0, rd=1, dest=2, alu=1 -> wb_out=0, dest_out=2, data_out=0x000000 (not the alu value).
REQ-032 Store then load: we=1, alu=5, wdata=0xABCDEF for one cycle; then rd=1, alu=5 -> data_out=0xABCDEF; alu=0x000105 also reads 0xABCDEF (wrap).
REQ-033 Same-cycle read/write: mem[7]=0x000011, then rd=1, we=1, alu=7, wdata=0x000022 -> data_out=0x000011; next cycle with rd=1 -> 0x000022.
REQ-034 Mid-operation reset: assert rst between edges during a load -> outputs clear asynchronously; memory retains 0xABCDEF at address 5.
